// File: rtl/seg_tally_decoder.sv
// seg_tally_decoder: recovers a 0..5 vote count from a 7-segment glyph bus.
//   clk        system clock
//   rst        synchronous active-high reset
//   segs_in    segment bus, asynchronous to clk (bit 6 = segs[6])
//   cnt_out    decoded vote count 0..5, frozen while cnt_valid is high
//   maj_out    1 when cnt_out >= 3
//   cnt_valid  cnt_out/maj_out hold a new, not yet accepted count
//   cnt_ready  downstream accepts the count (ignored while cnt_valid = 0)
//   glyph_err  one-cycle pulse when an illegal pattern settles
//   err_count  saturating count of illegal settled patterns
module seg_tally_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       segs_in,
  output logic [2:0]       cnt_out,
  output logic             maj_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             glyph_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned RUN_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SEG_W-1:0] sync1_q, sync2_q;
  logic [SEG_W-1:0] cand_q;
  logic [RUN_W-1:0] run_q;
  logic             settle_q;

  logic             pend_q, pend_d;
  logic [SEG_W-1:0] pend_code_q, pend_code_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic             first_q, first_d;

  logic [CNT_W-1:0] cnt_d;
  logic             maj_d;
  logic             valid_d;
  logic             err_d;
  logic [ERR_W-1:0] errcnt_d;

  logic             chg_c;
  logic             evt_c;
  logic [SEG_W-1:0] evt_code_c;
  logic             dec_legal_c;
  logic [CNT_W-1:0] dec_cnt_c;
  logic [RUN_W-1:0] run_inc_c;

  // Glyph lookup: {legal, count}
  function automatic logic [CNT_W:0] decode_glyph(input logic [SEG_W-1:0] g);
    logic [CNT_W:0] r;
    r = '0;
    case (g)
      7'h1B:   r = {1'b1, 3'd0};
      7'h3B:   r = {1'b1, 3'd1};
      7'h79:   r = {1'b1, 3'd2};
      7'h6D:   r = {1'b1, 3'd3};
      7'h70:   r = {1'b1, 3'd4};
      7'h77:   r = {1'b1, 3'd5};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer for the asynchronous segment bus
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= segs_in;
      sync2_q <= sync1_q;
    end
  end

  assign run_inc_c = run_q + RUN_W'(1);

  // Stability filter; settle_q pulses once in the cycle after the run reaches the window
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= '0;
      run_q    <= '0;
      settle_q <= 1'b0;
    end else if (sync2_q != cand_q) begin
      cand_q   <= sync2_q;
      run_q    <= RUN_W'(1);
      settle_q <= (STABLE_CYCLES == 32'd1);
    end else if (run_q != RUN_W'(STABLE_CYCLES)) begin
      run_q    <= run_inc_c;
      settle_q <= (run_inc_c == RUN_W'(STABLE_CYCLES));
    end else begin
      settle_q <= 1'b0;
    end
  end

  assign chg_c = (sync2_q != cand_q);

  // A fresh settle event takes priority over one parked during EMIT
  assign evt_c      = settle_q | pend_q;
  assign evt_code_c = settle_q ? cand_q : pend_code_q;
  assign {dec_legal_c, dec_cnt_c} = decode_glyph(evt_code_c);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_out     <= '0;
      maj_out     <= 1'b0;
      cnt_valid   <= 1'b0;
      glyph_err   <= 1'b0;
      err_count   <= '0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      last_q      <= '0;
      last_vld_q  <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_out     <= cnt_d;
      maj_out     <= maj_d;
      cnt_valid   <= valid_d;
      glyph_err   <= err_d;
      err_count   <= errcnt_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      last_q      <= last_d;
      last_vld_q  <= last_vld_d;
      first_q     <= first_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_out;
    maj_d       = maj_out;
    valid_d     = cnt_valid;
    err_d       = 1'b0;
    errcnt_d    = err_count;
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    last_d      = last_q;
    last_vld_d  = last_vld_q;
    first_d     = first_q;

    case (state_q)
      IDLE, SETTLE: begin
        if (state_q == IDLE) begin
          first_d = 1'b0;
        end
        if (evt_c) begin
          pend_d  = 1'b0;
          state_d = IDLE;
          if (!dec_legal_c) begin
            err_d = 1'b1;
            if (err_count != {ERR_W{1'b1}}) begin
              errcnt_d = err_count + ERR_W'(1);
            end
          end else if (!last_vld_q || (dec_cnt_c != last_q)) begin
            cnt_d   = dec_cnt_c;
            maj_d   = (dec_cnt_c >= 3'd3);
            valid_d = 1'b1;
            state_d = EMIT;
          end
        end else if ((state_q == IDLE) && (chg_c || first_q)) begin
          state_d = SETTLE;
        end
      end
      EMIT: begin
        // Keep only the newest pattern that settles while backpressured
        if (settle_q) begin
          pend_d      = 1'b1;
          pend_code_d = cand_q;
        end
        if (cnt_ready) begin
          last_d     = cnt_out;
          last_vld_d = 1'b1;
          valid_d    = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seg_tally_decoder.sv
module tb_seg_tally_decoder;

  localparam int unsigned STABLE = 4;
  localparam int unsigned ERR_W  = 8;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       segs_in;
  logic [2:0]       cnt_out;
  logic             maj_out;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             glyph_err;
  logic [ERR_W-1:0] err_count;

  always #5 clk = ~clk;

  seg_tally_decoder #(.STABLE_CYCLES(STABLE), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .segs_in(segs_in), .cnt_out(cnt_out), .maj_out(maj_out),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .glyph_err(glyph_err), .err_count(err_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0] segs;
    int         cnt;
    int         maj;
  } vec_t;
  vec_t vecs[6];

  logic [6:0] glyphs[6];

  // Behavioural reference: delay line, run length of identical samples, and
  // a report/ack bookkeeping of what downstream has seen.
  logic [6:0] m_s1, m_s2, m_cand, m_pend_code;
  int         m_run, m_cnt, m_last, m_errs;
  bit         m_evt, m_pend, m_valid, m_err;

  function automatic int glyph_value(input logic [6:0] g);
    for (int i = 0; i < 6; i++) if (glyphs[i] == g) return i;
    return -1;
  endfunction

  task automatic model_step();
    int c;
    logic [6:0] code;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_cand = '0; m_run = 0; m_evt = 0;
      m_pend = 0; m_pend_code = '0; m_valid = 0; m_err = 0;
      m_cnt = 0; m_last = -1; m_errs = 0;
      return;
    end
    m_err = 0;
    if (m_valid) begin
      if (m_evt) begin m_pend = 1; m_pend_code = m_cand; end
      if (cnt_ready) begin m_last = m_cnt; m_valid = 0; end
    end else if (m_evt || m_pend) begin
      code   = m_evt ? m_cand : m_pend_code;
      m_pend = 0;
      c = glyph_value(code);
      if (c < 0) begin
        m_err = 1;
        if (m_errs < ERR_MAX) m_errs++;
      end else if (c != m_last) begin
        m_cnt = c; m_valid = 1;
      end
    end
    if (m_s2 != m_cand) begin
      m_cand = m_s2; m_run = 1; m_evt = (STABLE == 1);
    end else if (m_run < STABLE) begin
      m_run++; m_evt = (m_run == STABLE);
    end else begin
      m_evt = 0;
    end
    m_s2 = m_s1;
    m_s1 = segs_in;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven right after this returns (negedge)
  task automatic tick();
    @(negedge clk);
    model_step();
    check("model_valid", int'(cnt_valid), int'(m_valid));
    check("model_cnt",   int'(cnt_out),   m_cnt);
    check("model_maj",   int'(maj_out),   int'(m_cnt >= 3));
    check("model_err",   int'(glyph_err), int'(m_err));
    check("model_errcnt", int'(err_count), m_errs);
  endtask

  int n_v, n_e, err_edge;

  initial begin
    glyphs[0] = 7'h1B; glyphs[1] = 7'h3B; glyphs[2] = 7'h79;
    glyphs[3] = 7'h6D; glyphs[4] = 7'h70; glyphs[5] = 7'h77;
    vecs[0] = '{7'h6D, 3, 1};
    vecs[1] = '{7'h1B, 0, 0};
    vecs[2] = '{7'h3B, 1, 0};
    vecs[3] = '{7'h79, 2, 0};
    vecs[4] = '{7'h70, 4, 1};
    vecs[5] = '{7'h77, 5, 1};

    rst = 1'b1; segs_in = '0; cnt_ready = 1'b1;
    repeat (3) tick();
    check("reset_valid", int'(cnt_valid), 0);
    check("reset_cnt", int'(cnt_out), 0);
    check("reset_errcnt", int'(err_count), 0);

    // Basic decode of every glyph, cnt_ready held high
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      segs_in = vecs[i].segs;
      for (int e = 1; e <= 7; e++) begin
        tick();
        if (e == 6) check("basic_early", int'(cnt_valid), 0);
      end
      check("basic_valid", int'(cnt_valid), 1);
      check("basic_cnt", int'(cnt_out), vecs[i].cnt);
      check("basic_maj", int'(maj_out), vecs[i].maj);
      tick();
      check("basic_pulse", int'(cnt_valid), 0);
    end

    // Glitch rejection around a reported 0x79
    segs_in = 7'h79;
    repeat (8) tick();
    segs_in = 7'h70;
    repeat (2) tick();
    segs_in = 7'h79;
    n_v = 0; n_e = 0;
    repeat (12) begin tick(); n_v += int'(cnt_valid); n_e += int'(glyph_err); end
    check("glitch_valid", n_v, 0);
    check("glitch_err", n_e, 0);

    // Duplicate suppression
    segs_in = 7'h1B;
    repeat (7) tick();
    check("dup_first_cnt", int'(cnt_out), 0);
    check("dup_first_valid", int'(cnt_valid), 1);
    tick();
    segs_in = 7'h79;
    tick();
    segs_in = 7'h1B;
    n_v = 0;
    repeat (12) begin tick(); n_v += int'(cnt_valid); end
    check("dup_suppressed", n_v, 0);

    // Illegal glyph, then saturation of the error counter
    segs_in = 7'h7F;
    n_e = 0; err_edge = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (glyph_err) begin n_e++; err_edge = e; end
    end
    check("illegal_pulses", n_e, 1);
    check("illegal_edge", err_edge, 7);
    check("illegal_errcnt", int'(err_count), 1);
    for (int k = 1; k <= (1 << ERR_W) + 2; k++) begin
      segs_in = k[0] ? 7'h7E : 7'h7F;
      repeat (7) begin tick(); n_e += int'(glyph_err); end
    end
    check("sat_errcnt", int'(err_count), ERR_MAX);
    check("sat_pulses", n_e, (1 << ERR_W) + 3);

    // Backpressure with a newer count settling during EMIT
    cnt_ready = 1'b0;
    segs_in = 7'h3B;
    repeat (7) tick();
    check("bp_valid", int'(cnt_valid), 1);
    check("bp_cnt", int'(cnt_out), 1);
    segs_in = 7'h77;
    n_v = 0;
    repeat (12) begin tick(); if (!cnt_valid || cnt_out != 3'd1) n_v++; end
    check("bp_frozen", n_v, 0);
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    check("bp_ack_gap", int'(cnt_valid), 0);
    tick();
    check("bp_next_valid", int'(cnt_valid), 1);
    check("bp_next_cnt", int'(cnt_out), 5);
    check("bp_next_maj", int'(maj_out), 1);
    cnt_ready = 1'b1;
    tick();

    // Reset while a count is pending
    cnt_ready = 1'b0;
    segs_in = 7'h1B;
    repeat (7) tick();
    check("rstemit_pre_valid", int'(cnt_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstemit_valid", int'(cnt_valid), 0);
    check("rstemit_cnt", int'(cnt_out), 0);
    check("rstemit_maj", int'(maj_out), 0);
    check("rstemit_err", int'(glyph_err), 0);
    check("rstemit_errcnt", int'(err_count), 0);
    n_v = 0;
    for (int e = 1; e <= 6; e++) begin tick(); n_v += int'(cnt_valid); end
    check("rstemit_early", n_v, 0);
    tick();
    check("rstemit_again_valid", int'(cnt_valid), 1);
    check("rstemit_again_cnt", int'(cnt_out), 0);
    cnt_ready = 1'b1;
    tick();

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      int r, hold;
      r = int'($urandom_range(0, 9));
      if (r < 7) segs_in = glyphs[$urandom_range(0, 5)];
      else segs_in = 7'($urandom);
      hold = (r == 9) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 10));
      rst = ($urandom_range(0, 59) == 0);
      for (int h = 0; h < hold; h++) begin
        cnt_ready = ($urandom_range(0, 9) < 7);
        tick();
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
